// File: rtl/qspi_cmd_dispatch.sv
// qspi_cmd_dispatch
//   Command sequencer behind the QSPI slave bridge. Pops MCU bytes from the
//   bridge RX FIFO, parses OP / ADDR / LEN / payload frames, drives a byte-wide
//   memory port and pushes read/status bytes into the bridge TX FIFO.
//   Opcodes: 0x01 WRITE, 0x02 READ, 0x03 STATUS; any other opcode sets err.
// Ports
//   clk, reset                  clock, async active-low reset
//   rd_empty/rd_data/rd_en      RX FIFO (first-word-fall-through)
//   wr_full/wr_data/wr_en       TX FIFO
//   mem_addr/mem_wdata/mem_we   memory write port (mem_we one cycle after pop)
//   mem_re/mem_rdata            memory read port (rdata valid 1 cycle after re)
//   busy                        frame in progress
//   err                         sticky error, cleared by a STATUS push
module qspi_cmd_dispatch #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_empty,
  input  logic [7:0]        rd_data,
  output logic              rd_en,
  input  logic              wr_full,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_RREQ, S_RWAIT, S_RPUSH, S_STAT
  } state_t;

  // Stall counter counts 0..TIMEOUT-1; the TIMEOUT-th stalled cycle aborts.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;         // next address of the frame
  logic [ADDR_W-1:0] maddr_q, maddr_d;       // address presented on the port
  logic [8:0]        cnt_q, cnt_d;           // bytes remaining (1..256)
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              is_rd_q, is_rd_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic rx_state, tx_state, stall, tmo_hit;

  assign rx_state = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                    (state_q == S_LEN)  || (state_q == S_WDATA);
  assign tx_state = (state_q == S_RPUSH) || (state_q == S_STAT);

  // rd_en is gated by reset so nothing pops while reset is held in IDLE.
  assign rd_en     = reset && rx_state && !rd_empty;
  assign wr_en     = tx_state && !wr_full;
  assign wr_data   = (state_q == S_RPUSH) ? hold_q :
                     (state_q == S_STAT)  ? {6'b0, err_q, 1'b1} : 8'h00;
  assign mem_re    = (state_q == S_RREQ);
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_addr  = maddr_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

  // IDLE never counts as stalled: waiting for an opcode is not a timeout.
  assign stall   = (rx_state && (state_q != S_IDLE) && rd_empty) ||
                   (tx_state && wr_full);
  assign tmo_hit = (TIMEOUT > 0) && stall && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    maddr_d = maddr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    is_rd_d = is_rd_q;
    tmo_d   = stall ? tmo_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: if (rd_en) begin
        case (rd_data)
          8'h01:   begin is_rd_d = 1'b0; state_d = S_ADDR; end
          8'h02:   begin is_rd_d = 1'b1; state_d = S_ADDR; end
          8'h03:   state_d = S_STAT;
          default: err_d = 1'b1;
        endcase
      end
      S_ADDR: if (rd_en) begin
        addr_d  = rd_data[ADDR_W-1:0];
        state_d = S_LEN;
      end
      S_LEN: if (rd_en) begin
        cnt_d = {(rd_data == 8'h00), rd_data};  // LEN=0 encodes 256
        if (is_rd_q) begin
          maddr_d = addr_q;
          state_d = S_RREQ;
        end else begin
          state_d = S_WDATA;
        end
      end
      S_WDATA: if (rd_en) begin
        we_d    = 1'b1;
        wdata_d = rd_data;
        maddr_d = addr_q;
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 9'd1;
        if (cnt_q == 9'd1) state_d = S_IDLE;
      end
      S_RREQ: begin
        addr_d  = addr_q + 1'b1;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        hold_d  = mem_rdata;
        state_d = S_RPUSH;
      end
      S_RPUSH: if (wr_en) begin
        cnt_d   = cnt_q - 9'd1;
        maddr_d = addr_q;
        state_d = (cnt_q == 9'd1) ? S_IDLE : S_RREQ;
      end
      S_STAT: if (wr_en) begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A timeout only fires on a stalled cycle, so no pop/push is lost here.
    if (tmo_hit) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      maddr_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      is_rd_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      is_rd_q <= is_rd_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
